control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Multi-cycle controller FSM for the ProjectB processor. Sits directly upstream of PC_Counter and drives its up/clear inputs.
- Sequences fetch/decode/execute for each 16-bit instruction.
- Issues control words to the instruction register, data memory, register file and ALU.
- Exposes its current state for the board display.

Parameters:
- D_ADDR_W, 8, data-memory address width
- RF_ADDR_W, 4, register-file address width

Ports:
- clk  input  1  system clock, rising edge
- clear  input  1  asynchronous, active-high reset; forces Init
- IR  input  16  instruction register contents, stable from the cycle after Fetch
- PC_up  output  1  increment PC (to PC_Counter up)
- PC_clr  output  1  clear PC (to PC_Counter clear)
- IR_ld  output  1  load instruction register from instruction memory
- D_addr  output  D_ADDR_W  data-memory address
- D_wr  output  1  data-memory write enable
- RF_s  output  1  register-file write-data select: 1 = memory, 0 = ALU
- RF_W_addr  output  RF_ADDR_W  register-file write address
- RF_W_en  output  1  register-file write enable
- RF_Ra_addr  output  RF_ADDR_W  read port A address
- RF_Rb_addr  output  RF_ADDR_W  read port B address
- ALU_s0  output  3  ALU op: 000 pass-zero, 001 add, 010 sub
- state  output  4  current state code (display/debug)

Behaviour:
- Opcode field is IR[15:12].
  - 0000 NOOP
  - 0001 STORE: D_addr=IR[11:4], Ra=IR[3:0]
  - 0010 LOAD: D_addr=IR[11:4], Rd=IR[3:0]
  - 0011 ADD: Ra=IR[11:8], Rb=IR[7:4], Rd=IR[3:0]
  - 0100 SUB: same fields as ADD
  - 0101 HALT
  - 0110-1111: illegal, executed as NOOP
- State codes: Init=0, Fetch=1, Decode=2, NoOp=3, LoadA=4, LoadB=5, Store=6, Add=7, Sub=8, Halt=9.
- State register is async-reset to Init. Outputs are Moore, combinational from registered state and IR.
- Default for every output in every state is 0, except where a state says otherwise.
- Outputs during clear and in Init: PC_clr=1, all others 0, state=0.
- Transitions:
  - Init -> Fetch, unconditionally, next edge.
  - Fetch: IR_ld=1, PC_up=1. IR captures mem[PC] and PC increments on the same edge. Fetch -> Decode.
  - Decode: all enables 0. Branches on IR[15:12] to NoOp/LoadA/Store/Add/Sub/Halt. Illegal opcodes go to NoOp.
  - NoOp -> Fetch.
  - LoadA: D_addr driven. Covers the 1-cycle data-memory read latency. -> LoadB.
  - LoadB: D_addr held, RF_s=1, RF_W_addr=Rd, RF_W_en=1. -> Fetch.
  - Store: D_addr, RF_Ra_addr=Ra, D_wr=1 for exactly one cycle. -> Fetch.
  - Add: RF_Ra_addr, RF_Rb_addr, RF_W_addr, RF_W_en=1, RF_s=0, ALU_s0=001. -> Fetch.
  - Sub: as Add with ALU_s0=010. -> Fetch.
  - Halt: all enables 0. Remains in Halt until clear.
- Instruction latency, counted from the Fetch cycle: NOOP/STORE/ADD/SUB 3 cycles, LOAD 4 cycles.
- PC_up is never asserted outside Fetch. PC wrap (127 -> 0) is owned by PC_Counter; the controller is unaware of it.
- At most one of D_wr and RF_W_en is 1 in any cycle.
- clear asserted mid-instruction: state goes to Init immediately (async). Any write enable drops the same cycle. No partial writes after clear.
- clear held for multiple cycles: remains in Init with PC_clr=1.
- Address fields are driven only in the states that use them; otherwise 0.

Optional Feature:
- Macro SINGLE_STEP_EN. When defined, adds input port step (1 bit, synchronous, level).
- With the macro: Fetch holds with IR_ld=0 and PC_up=0 while step=0. When step=1, Fetch asserts IR_ld=1 and PC_up=1 for that cycle and advances to Decode.
- Without the macro: no step port; Fetch always advances after one cycle.

Test Plan:
- clear=1 for 2 cycles, then 0 -> state=0 with PC_clr=1 while clear is high; next edge state=1 with IR_ld=PC_up=1; next state=2.
- IR=16'h2A53 (LOAD mem[0xA5] -> R3) -> states 1,2,4,5,1. In LoadB: D_addr=0xA5, RF_s=1, RF_W_addr=3, RF_W_en=1. D_wr=0 throughout.
- IR=16'h3124 (ADD R1+R2 -> R4), then IR=16'h4124 (SUB) -> Add state: Ra=1, Rb=2, W=4, RF_W_en=1, ALU_s0=001, RF_s=0. Sub state: ALU_s0=010. Each is 3 cycles.
- IR=16'h1F07 (STORE R7 -> mem[0xF0]) -> D_wr=1 for exactly one cycle, D_addr=0xF0, RF_Ra_addr=7, RF_W_en=0.
- IR=16'h5000 (HALT) then 20 cycles idle -> state stays 9, PC_up=0 for all 20. IR=16'hF000 -> routes through NoOp back to Fetch.
- Assert clear asynchronously mid-LoadB -> RF_W_en falls before the next edge, state=0, PC_clr=1. With SINGLE_STEP_EN and step=0 for 5 cycles -> stays in state 1 with PC_up=0.

Source files
------------

// File: rtl/control_unit_if.sv
// Control bus between the multi-cycle controller and the ProjectB datapath:
// instruction word in, PC / IR / memory / register-file / ALU control out.
interface control_unit_if #(
    parameter int D_ADDR_W  = 8,
    parameter int RF_ADDR_W = 4
);
    logic [15:0]          IR;
    logic                 PC_up;
    logic                 PC_clr;
    logic                 IR_ld;
    logic [D_ADDR_W-1:0]  D_addr;
    logic                 D_wr;
    logic                 RF_s;
    logic [RF_ADDR_W-1:0] RF_W_addr;
    logic                 RF_W_en;
    logic [RF_ADDR_W-1:0] RF_Ra_addr;
    logic [RF_ADDR_W-1:0] RF_Rb_addr;
    logic [2:0]           ALU_s0;
    logic [3:0]           state;

    modport master (
        input  IR,
        output PC_up, PC_clr, IR_ld, D_addr, D_wr, RF_s, RF_W_addr,
               RF_W_en, RF_Ra_addr, RF_Rb_addr, ALU_s0, state
    );

    modport slave (
        output IR,
        input  PC_up, PC_clr, IR_ld, D_addr, D_wr, RF_s, RF_W_addr,
               RF_W_en, RF_Ra_addr, RF_Rb_addr, ALU_s0, state
    );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute controller for ProjectB (Moore outputs).
// Optional macro SINGLE_STEP_EN adds a level-sensitive step input that gates Fetch.
module control_unit #(
    parameter int D_ADDR_W  = 8,
    parameter int RF_ADDR_W = 4
) (
    input  logic clk,
    input  logic clear,
`ifdef SINGLE_STEP_EN
    input  logic step,
`endif
    control_unit_if.master bus
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    state_t state_reg;
    logic   fetch_go;

`ifdef SINGLE_STEP_EN
    assign fetch_go = step;
`else
    assign fetch_go = 1'b1;
`endif

    // Instruction fields; LOAD/STORE share the low nibble as Rd or Ra.
    logic [D_ADDR_W-1:0]  mem_addr;
    logic [RF_ADDR_W-1:0] fld_hi;
    logic [RF_ADDR_W-1:0] fld_mid;
    logic [RF_ADDR_W-1:0] fld_lo;

    assign mem_addr = D_ADDR_W'(bus.IR[11:4]);
    assign fld_hi   = RF_ADDR_W'(bus.IR[11:8]);
    assign fld_mid  = RF_ADDR_W'(bus.IR[7:4]);
    assign fld_lo   = RF_ADDR_W'(bus.IR[3:0]);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_reg <= S_INIT;
        end else begin
            case (state_reg)
                S_INIT:   state_reg <= S_FETCH;
                S_FETCH:  if (fetch_go) state_reg <= S_DECODE;
                S_DECODE: begin
                    case (bus.IR[15:12])
                        4'h1:    state_reg <= S_STORE;
                        4'h2:    state_reg <= S_LOAD_A;
                        4'h3:    state_reg <= S_ADD;
                        4'h4:    state_reg <= S_SUB;
                        4'h5:    state_reg <= S_HALT;
                        default: state_reg <= S_NOOP;
                    endcase
                end
                S_LOAD_A: state_reg <= S_LOAD_B;
                S_HALT:   state_reg <= S_HALT;
                default:  state_reg <= S_FETCH;
            endcase
        end
    end

    // Outputs depend only on the state register and IR, so an async clear
    // removes every write enable within the same cycle.
    always_comb begin
        bus.PC_up      = 1'b0;
        bus.PC_clr     = 1'b0;
        bus.IR_ld      = 1'b0;
        bus.D_addr     = '0;
        bus.D_wr       = 1'b0;
        bus.RF_s       = 1'b0;
        bus.RF_W_addr  = '0;
        bus.RF_W_en    = 1'b0;
        bus.RF_Ra_addr = '0;
        bus.RF_Rb_addr = '0;
        bus.ALU_s0     = 3'b000;
        bus.state      = state_reg;

        case (state_reg)
            S_INIT: bus.PC_clr = 1'b1;
            S_FETCH: begin
                bus.IR_ld = fetch_go;
                bus.PC_up = fetch_go;
            end
            S_LOAD_A: bus.D_addr = mem_addr;
            S_LOAD_B: begin
                bus.D_addr    = mem_addr;
                bus.RF_s      = 1'b1;
                bus.RF_W_addr = fld_lo;
                bus.RF_W_en   = 1'b1;
            end
            S_STORE: begin
                bus.D_addr     = mem_addr;
                bus.RF_Ra_addr = fld_lo;
                bus.D_wr       = 1'b1;
            end
            S_ADD, S_SUB: begin
                bus.RF_Ra_addr = fld_hi;
                bus.RF_Rb_addr = fld_mid;
                bus.RF_W_addr  = fld_lo;
                bus.RF_W_en    = 1'b1;
                bus.ALU_s0     = (state_reg == S_ADD) ? 3'b001 : 3'b010;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus queues hand-computed expected
// control words per cycle, a monitor pops and compares them.
module tb_control_unit;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_up;
        logic       pc_clr;
        logic       ir_ld;
        logic [7:0] d_addr;
        logic       d_wr;
        logic       rf_s;
        logic [3:0] w_addr;
        logic       w_en;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [2:0] alu;
    } exp_t;

    logic clk;
    logic clear;
`ifdef SINGLE_STEP_EN
    logic step;
`endif

    control_unit_if #(.D_ADDR_W(8), .RF_ADDR_W(4)) bus ();

    control_unit #(.D_ADDR_W(8), .RF_ADDR_W(4)) dut (
        .clk   (clk),
        .clear (clear),
`ifdef SINGLE_STEP_EN
        .step  (step),
`endif
        .bus   (bus)
    );

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    event  sample_ev;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t e_zero(input logic [3:0] st);
        exp_t e;
        e    = '0;
        e.st = st;
        return e;
    endfunction

    function automatic exp_t e_init();
        exp_t e;
        e        = e_zero(4'd0);
        e.pc_clr = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_fetch();
        exp_t e;
        e       = e_zero(4'd1);
        e.pc_up = 1'b1;
        e.ir_ld = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_loada(input logic [7:0] a);
        exp_t e;
        e        = e_zero(4'd4);
        e.d_addr = a;
        return e;
    endfunction

    function automatic exp_t e_loadb(input logic [7:0] a, input logic [3:0] rd);
        exp_t e;
        e        = e_zero(4'd5);
        e.d_addr = a;
        e.rf_s   = 1'b1;
        e.w_addr = rd;
        e.w_en   = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_store(input logic [7:0] a, input logic [3:0] ra);
        exp_t e;
        e        = e_zero(4'd6);
        e.d_addr = a;
        e.ra     = ra;
        e.d_wr   = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_alu(input logic [3:0] st, input logic [3:0] ra,
                                   input logic [3:0] rb, input logic [3:0] rd,
                                   input logic [2:0] op);
        exp_t e;
        e        = e_zero(st);
        e.ra     = ra;
        e.rb     = rb;
        e.w_addr = rd;
        e.w_en   = 1'b1;
        e.alu    = op;
        return e;
    endfunction

    // Called at posedge+1: queue the expectation for the current cycle, then advance.
    task automatic cyc(input exp_t e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t  e;
        exp_t  act;
        string t;
        forever begin
            @(negedge clk or sample_ev);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                t   = tag_q.pop_front();
                act = '{st: bus.state, pc_up: bus.PC_up, pc_clr: bus.PC_clr,
                        ir_ld: bus.IR_ld, d_addr: bus.D_addr, d_wr: bus.D_wr,
                        rf_s: bus.RF_s, w_addr: bus.RF_W_addr, w_en: bus.RF_W_en,
                        ra: bus.RF_Ra_addr, rb: bus.RF_Rb_addr, alu: bus.ALU_s0};
                n_cmp++;
                if (act !== e) begin
                    n_bad++;
                    $display("FAIL %s: got %h (state=%0d) expected %h (state=%0d)",
                             t, act, act.st, e, e.st);
                end else begin
                    $display("ok   %s: state=%0d word=%h", t, act.st, act);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        clear  = 1'b0;
        bus.IR = 16'h0000;
`ifdef SINGLE_STEP_EN
        step   = 1'b1;
`endif
        #2 clear = 1'b1;
        @(posedge clk);
        #1;
        cyc(e_init(), "reset_hold0");
        cyc(e_init(), "reset_hold1");
        clear = 1'b0;
        cyc(e_init(), "init");

        // LOAD mem[0xA5] -> R3
        bus.IR = 16'h2A53;
        cyc(e_fetch(), "load_fetch");
        cyc(e_zero(4'd2), "load_decode");
        cyc(e_loada(8'hA5), "load_a");
        cyc(e_loadb(8'hA5, 4'd3), "load_b");

        // ADD R1+R2 -> R4, then SUB
        bus.IR = 16'h3124;
        cyc(e_fetch(), "add_fetch");
        cyc(e_zero(4'd2), "add_decode");
        cyc(e_alu(4'd7, 4'd1, 4'd2, 4'd4, 3'b001), "add_exec");
        bus.IR = 16'h4124;
        cyc(e_fetch(), "sub_fetch");
        cyc(e_zero(4'd2), "sub_decode");
        cyc(e_alu(4'd8, 4'd1, 4'd2, 4'd4, 3'b010), "sub_exec");

        // STORE R7 -> mem[0xF0]
        bus.IR = 16'h1F07;
        cyc(e_fetch(), "store_fetch");
        cyc(e_zero(4'd2), "store_decode");
        cyc(e_store(8'hF0, 4'd7), "store_exec");

        // Illegal opcode and plain NOOP both route through NoOp
        bus.IR = 16'hF000;
        cyc(e_fetch(), "illegal_fetch");
        cyc(e_zero(4'd2), "illegal_decode");
        cyc(e_zero(4'd3), "illegal_noop");
        bus.IR = 16'h0000;
        cyc(e_fetch(), "noop_fetch");
        cyc(e_zero(4'd2), "noop_decode");
        cyc(e_zero(4'd3), "noop_exec");

        // HALT is sticky for 20 idle cycles
        bus.IR = 16'h5000;
        cyc(e_fetch(), "halt_fetch");
        cyc(e_zero(4'd2), "halt_decode");
        for (int i = 0; i < 20; i++) cyc(e_zero(4'd9), "halt_idle");

        clear = 1'b1;
        #1;
        cyc(e_init(), "halt_clear0");
        cyc(e_init(), "halt_clear1");
        clear = 1'b0;
        cyc(e_init(), "halt_init");

        // Async clear in the middle of LoadB
        bus.IR = 16'h2A53;
        cyc(e_fetch(), "clr_fetch");
        cyc(e_zero(4'd2), "clr_decode");
        cyc(e_loada(8'hA5), "clr_load_a");
        exp_q.push_back(e_loadb(8'hA5, 4'd3));
        tag_q.push_back("clr_load_b");
        #5;
        clear = 1'b1;
        #1;
        exp_q.push_back(e_init());
        tag_q.push_back("clr_async");
        ->sample_ev;
        @(posedge clk);
        #1;
        cyc(e_init(), "clr_hold0");
        cyc(e_init(), "clr_hold1");
        clear = 1'b0;
        cyc(e_init(), "clr_init");

`ifdef SINGLE_STEP_EN
        step = 1'b0;
        for (int i = 0; i < 5; i++) cyc(e_zero(4'd1), "step_hold");
        step = 1'b1;
`endif
        cyc(e_fetch(), "post_fetch");
        cyc(e_zero(4'd2), "post_decode");
        cyc(e_loada(8'hA5), "post_load_a");

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
